// File: rtl/frame_stuffer_tx_pkg.sv
// Shared framing protocol constants and FSM state encoding for the frame stuffer
// and its peers (interface, core, receiver).
package frame_stuffer_tx_pkg;

   localparam int unsigned PKG_DATA_SIZE     = 64;
   localparam int unsigned PKG_PREAMBLE_SIZE = 7;
   localparam int unsigned PKG_CRC_SIZE      = 4;
   localparam int unsigned PKG_FRAME_BYTES   = PKG_PREAMBLE_SIZE + PKG_DATA_SIZE + PKG_CRC_SIZE;

   localparam logic [7:0] PKG_FRAME_START = 8'h06;
   localparam logic [7:0] PKG_FRAME_END   = 8'h07;
   localparam logic [7:0] PKG_ESC_VAL     = 8'h14;
   localparam logic [7:0] PKG_ESC_XOR     = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_ESC2  = 3'd3,
      ST_END   = 3'd4
   } state_t;

endpackage

// File: rtl/frame_stuffer_tx_esc_detect.sv
// Flags payload bytes that collide with a framing or escape code; shared with the receiver.
module esc_detect
   import frame_stuffer_tx_pkg::*;
#(
   parameter logic [7:0] FRAME_START = PKG_FRAME_START,
   parameter logic [7:0] FRAME_END   = PKG_FRAME_END,
   parameter logic [7:0] ESC_VAL     = PKG_ESC_VAL
) (
   input  logic [7:0] byte_i,
   output logic       needs_esc_o
);

   assign needs_esc_o = (byte_i == FRAME_START) || (byte_i == FRAME_END) || (byte_i == ESC_VAL);

endmodule

// File: rtl/frame_stuffer_tx.sv
// Byte-stuffing frame transmitter: wraps a captured frame in START/END codes,
// escaping any payload byte that collides with a control code.
module frame_stuffer_tx
   import frame_stuffer_tx_pkg::*;
#(
   parameter int unsigned DATA_SIZE     = PKG_DATA_SIZE,
   parameter int unsigned PREAMBLE_SIZE = PKG_PREAMBLE_SIZE,
   parameter int unsigned CRC_SIZE      = PKG_CRC_SIZE,
   parameter logic [7:0]  FRAME_START   = PKG_FRAME_START,
   parameter logic [7:0]  FRAME_END     = PKG_FRAME_END,
   parameter logic [7:0]  ESC_VAL       = PKG_ESC_VAL,
   parameter logic [7:0]  ESC_XOR       = PKG_ESC_XOR,
   localparam int unsigned FRAME_BYTES  = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [0:FRAME_BYTES*8-1] fin,
   input  logic                     fin_valid,
   output logic                     fin_ready,
   output logic [7:0]               tx_byte,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     busy
);

   localparam int unsigned IDX_W = $clog2(FRAME_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [0:FRAME_BYTES*8-1] frame_q, frame_d;
   logic [7:0]               tx_byte_q, tx_byte_d;
   logic                     tx_valid_q, tx_valid_d;
   logic [7:0]               cur_byte, nxt_byte;
   logic                     cur_esc, nxt_esc;

   assign cur_byte = frame_q[int'(idx_q)*8 +: 8];
   assign nxt_byte = frame_d[int'(idx_d)*8 +: 8];

   esc_detect #(
      .FRAME_START (FRAME_START),
      .FRAME_END   (FRAME_END),
      .ESC_VAL     (ESC_VAL)
   ) u_esc_cur (
      .byte_i      (cur_byte),
      .needs_esc_o (cur_esc)
   );

   // Looks ahead at the byte the next state will present so tx_byte can be registered.
   esc_detect #(
      .FRAME_START (FRAME_START),
      .FRAME_END   (FRAME_END),
      .ESC_VAL     (ESC_VAL)
   ) u_esc_nxt (
      .byte_i      (nxt_byte),
      .needs_esc_o (nxt_esc)
   );

   // Next-state, byte counter and frame capture.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      unique case (state_q)
         ST_IDLE: begin
            if (fin_valid) begin
               frame_d = fin;
               idx_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tx_ready) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (tx_ready) begin
               if (cur_esc)               state_d = ST_ESC2;
               else if (idx_q == LAST_IDX) state_d = ST_END;
               else                        idx_d   = idx_q + IDX_W'(1);
            end
         end
         ST_ESC2: begin
            if (tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_END;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_DATA;
               end
            end
         end
         ST_END: begin
            if (tx_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output byte for the state being entered; unchanged while the transmitter stalls.
   always_comb begin
      tx_valid_d = 1'b1;
      tx_byte_d  = 8'h00;
      unique case (state_d)
         ST_IDLE:  tx_valid_d = 1'b0;
         ST_START: tx_byte_d  = FRAME_START;
         ST_DATA:  tx_byte_d  = nxt_esc ? ESC_VAL : nxt_byte;
         ST_ESC2:  tx_byte_d  = nxt_byte ^ ESC_XOR;
         ST_END:   tx_byte_d  = FRAME_END;
         default:  tx_valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         frame_q    <= '0;
         tx_byte_q  <= 8'h00;
         tx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         tx_byte_q  <= tx_byte_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign tx_byte   = tx_byte_q;
   assign tx_valid  = tx_valid_q;
   assign busy      = (state_q != ST_IDLE);
   assign fin_ready = (state_q == ST_IDLE) && !rst;

endmodule

// File: tb/tb_frame_stuffer_tx.sv
// Directed self-checking bench for frame_stuffer_tx: framing, escaping, stalls,
// ignored fin_valid, mid-frame reset and back-to-back frames.
module tb_frame_stuffer_tx;

   localparam int FB = 75;

   logic              clk = 1'b0;
   logic              rst;
   logic [0:FB*8-1]   fin;
   logic              fin_valid;
   logic              fin_ready;
   logic [7:0]        tx_byte;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int ncyc, stall_bad, busy_bad, timed_out;

   frame_stuffer_tx dut (
      .clk       (clk),
      .rst       (rst),
      .fin       (fin),
      .fin_valid (fin_valid),
      .fin_ready (fin_ready),
      .tx_byte   (tx_byte),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_fin_all(input logic [7:0] v);
      for (int k = 0; k < FB; k++) fin[8*k +: 8] = v;
   endtask

   task automatic exp_plain(input logic [7:0] v);
      exp_q.delete();
      exp_q.push_back(8'h06);
      for (int k = 0; k < FB; k++) exp_q.push_back(v);
      exp_q.push_back(8'h07);
   endtask

   // Called #1 after an edge in IDLE; leaves the bench #1 after the START edge.
   task automatic start_frame(input string tag, input bit hold);
      fin_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) fin_valid = 1'b0;
      check({tag, "_first_valid"}, 32'(tx_valid), 32'd1);
      check({tag, "_first_byte"}, 32'(tx_byte), 32'h06);
   endtask

   // mode 0: ready always; 1: ready every other cycle; 2: ready always plus a
   // stray fin_valid with new fin mid-frame; 3: stop after 11 transferred bytes.
   task automatic collect(input int mode);
      logic       rdy;
      logic       prev_hold;
      logic [7:0] prev_byte;
      got.delete();
      ncyc = 0; stall_bad = 0; busy_bad = 0; timed_out = 1;
      prev_hold = 1'b0; prev_byte = 8'h00;
      while (ncyc < 1000) begin
         rdy = (mode == 1) ? ((ncyc % 2) == 1) : 1'b1;
         tx_ready = rdy;
         if (mode == 2 && ncyc == 5) begin
            set_fin_all(8'h55);
            fin_valid = 1'b1;
         end
         if (mode == 2 && ncyc == 6) fin_valid = 1'b0;
         if (prev_hold && (tx_byte !== prev_byte || tx_valid !== 1'b1)) stall_bad++;
         if (busy !== 1'b1) busy_bad++;
         ncyc++;
         if (tx_valid && rdy) got.push_back(tx_byte);
         prev_hold = tx_valid && !rdy;
         prev_byte = tx_byte;
         @(posedge clk); #1;
         if (got.size() > 0 && got[$] == 8'h07) begin timed_out = 0; break; end
         if (mode == 3 && got.size() == 11) begin timed_out = 0; break; end
      end
      tx_ready = 1'b1;
   endtask

   task automatic check_stream(input string tag);
      int bad = 0;
      check({tag, "_timeout"}, 32'(timed_out), 32'd0);
      check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] !== exp_q[i]) bad++;
      check({tag, "_bytes_bad"}, 32'(bad), 32'd0);
      check({tag, "_busy_drop"}, 32'(busy_bad), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_ready"}, 32'(fin_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; fin_valid = 1'b0; tx_ready = 1'b0; fin = '0;

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_byte", 32'(tx_byte), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fin_ready", 32'(fin_ready), 32'd0);
      rst = 1'b0; #1;
      check("post_rst_fin_ready", 32'(fin_ready), 32'd1);

      // All-AA frame, ready held: 77 cycles, no bubbles
      tx_ready = 1'b1;
      set_fin_all(8'hAA);
      start_frame("aa", 1'b0);
      collect(0);
      exp_plain(8'hAA);
      check_stream("aa");
      check("aa_cycles", 32'(ncyc), 32'd77);
      check_idle("aa");

      // Escaped bytes at both ends
      set_fin_all(8'h00);
      fin[0 +: 8] = 8'h06;
      fin[8 +: 8] = 8'h14;
      fin[8*74 +: 8] = 8'h07;
      start_frame("esc", 1'b0);
      collect(0);
      exp_q.delete();
      exp_q.push_back(8'h06);
      exp_q.push_back(8'h14); exp_q.push_back(8'h26);
      exp_q.push_back(8'h14); exp_q.push_back(8'h34);
      for (int k = 0; k < 72; k++) exp_q.push_back(8'h00);
      exp_q.push_back(8'h14); exp_q.push_back(8'h27);
      exp_q.push_back(8'h07);
      check_stream("esc");
      check("esc_cycles", 32'(ncyc), 32'd80);
      check_idle("esc");

      // Stalling transmitter
      set_fin_all(8'hAA);
      start_frame("stall", 1'b0);
      collect(1);
      exp_plain(8'hAA);
      check_stream("stall");
      check("stall_hold_bad", 32'(stall_bad), 32'd0);
      check_idle("stall");

      // Stray fin_valid with different fin mid-frame is ignored
      set_fin_all(8'hAA);
      start_frame("ign", 1'b0);
      collect(2);
      exp_plain(8'hAA);
      check_stream("ign");
      check_idle("ign");

      // Reset after 10 data bytes aborts the frame
      set_fin_all(8'h3C);
      start_frame("abort", 1'b0);
      collect(3);
      check("abort_partial_len", 32'(got.size()), 32'd11);
      rst = 1'b1;
      fin_valid = 1'b1;
      @(posedge clk); #1;
      check("abort_valid", 32'(tx_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      fin_valid = 1'b0;
      begin
         int seen = 0;
         for (int c = 0; c < 3; c++) begin
            if (tx_valid !== 1'b0) seen++;
            @(posedge clk); #1;
         end
         check("abort_no_end", 32'(seen), 32'd0);
      end
      set_fin_all(8'h11);
      start_frame("restart", 1'b0);
      collect(0);
      exp_plain(8'h11);
      check_stream("restart");

      // Back-to-back frames with fin_valid held
      set_fin_all(8'h5A);
      start_frame("b2b1", 1'b1);
      collect(0);
      exp_plain(8'h5A);
      check_stream("b2b1");
      check_idle("b2b_gap");
      @(posedge clk); #1;
      fin_valid = 1'b0;
      check("b2b2_first_valid", 32'(tx_valid), 32'd1);
      check("b2b2_first_byte", 32'(tx_byte), 32'h06);
      collect(0);
      check_stream("b2b2");
      check("b2b2_cycles", 32'(ncyc), 32'd77);
      check_idle("b2b2");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
